reg_file: RTL

- 8 x 16-bit general-purpose register file; sits directly upstream of the 16-bit adder/ALU.
- Two combinational read ports drive the adder operands a and b.
- A carry-flag register drives the adder carry-in (cin).
- The write port and the carry-flag write accept the adder's sum and cout on writeback, closing the ALU loop.

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_if.sv | 31 +++
 rtl/reg_file_rd_port.sv | 33 +++
 rtl/reg_file.sv | 71 +++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared register-file types and sizing, also used by the adder/ALU.
// Build option: REG_FILE_BYPASS_EN selects write-first forwarding in reg_file.
package reg_file_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;
  localparam int RF_NREGS  = 2 ** RF_ADDR_W;

  // Index of the hardwired-zero register.
  localparam int REG_ZERO = 0;

  typedef logic [RF_DATA_W-1:0] reg_word_t;
  typedef logic [RF_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bus: two read ports, one write port, carry-flag access.
// master = ALU/adder side, slave = reg_file.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              cf_we;
  logic              cf_in;
  logic              cf_out;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, cf_we, cf_in,
    input  rd_data_a, rd_data_b, cf_out
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, cf_we, cf_in,
    output rd_data_a, rd_data_b, cf_out
  );

endinterface

// File: rtl/reg_file_rd_port.sv
// Purpose: one combinational read port with R0 masking (forwarding under REG_FILE_BYPASS_EN).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the port always returns data.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                rd_addr,
`ifdef REG_FILE_BYPASS_EN
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
`endif
  output logic [DATA_W-1:0]                rd_data
);

  always_comb begin
    rd_data = regs[rd_addr];
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
`endif
    // Applied last so R0 masking also overrides forwarding.
    if (rd_addr == ADDR_W'(REG_ZERO)) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Purpose: 8x16 register file plus carry flag feeding the adder; REG_FILE_BYPASS_EN enables write-first forwarding.
// Latency: reads zero cycles, writes visible one cycle after the edge (same cycle with bypass).
// Backpressure: none; writes and carry updates are always accepted.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  rf
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic                         cf_q;

  // Entry 0 is only ever cleared; it is never a write target.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
      cf_q <= 1'b0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (rf.wr_en && (rf.wr_addr == ADDR_W'(i))) begin
          regs[i] <= rf.wr_data;
        end
      end
      if (rf.cf_we) begin
        cf_q <= rf.cf_in;
      end
    end
  end

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port_a (
    .regs    (regs),
    .rd_addr (rf.rd_addr_a),
`ifdef REG_FILE_BYPASS_EN
    .wr_en   (rf.wr_en),
    .wr_addr (rf.wr_addr),
    .wr_data (rf.wr_data),
`endif
    .rd_data (rf.rd_data_a)
  );

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port_b (
    .regs    (regs),
    .rd_addr (rf.rd_addr_b),
`ifdef REG_FILE_BYPASS_EN
    .wr_en   (rf.wr_en),
    .wr_addr (rf.wr_addr),
    .wr_data (rf.wr_data),
`endif
    .rd_data (rf.rd_data_b)
  );

`ifdef REG_FILE_BYPASS_EN
  assign rf.cf_out = rf.cf_we ? rf.cf_in : cf_q;
`else
  assign rf.cf_out = cf_q;
`endif

endmodule
